// File: rtl/mul_share_pkg.sv
// mul_share_pkg: types and helpers shared by mul_share_arbiter, its response
// FIFO and the two-stage multiplier.
package mul_share_pkg;

  // Operator encoding used by the CPU datapath; _ADD is the idle filler.
  typedef enum logic [2:0] {
    _ADD    = 3'd0,
    _MUL    = 3'd1,
    _MULH   = 3'd2,
    _MULHSU = 3'd3,
    _MULHU  = 3'd4
  } OPERATOR_t;

  localparam int DATA_W    = 32;
  // Field widths of a FIFO entry are fixed here; narrower ids/tags are
  // zero-extended into them by the arbiter.
  localparam int ID_W_MAX  = 4;
  localparam int TAG_W_MAX = 8;

  typedef struct packed {
    logic [ID_W_MAX-1:0]  id;
    logic [TAG_W_MAX-1:0] tag;
    logic [DATA_W-1:0]    data;
  } rsp_entry_t;

  // Width of a requester index.
  function automatic int req_id_w(input int num_req);
    return (num_req > 1) ? $clog2(num_req) : 1;
  endfunction

  // (base + offs) mod n for base < n and offs < n.
  function automatic int rr_index(input int base, input int offs, input int n);
    int sum;
    sum = base + offs;
    return (sum >= n) ? sum - n : sum;
  endfunction

endpackage

// File: rtl/mul_rsp_fifo.sv
// mul_rsp_fifo: DEPTH-entry response FIFO of rsp_entry_t with synchronous
// active-low reset. Storage is not reset; empty/count qualify the head.
module mul_rsp_fifo
  import mul_share_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  rsp_entry_t       entry_i,
  input  logic             pop_i,
  output rsp_entry_t       head_o,
  output logic [CNT_W-1:0] count_o,
  output logic             empty_o,
  output logic             full_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  rsp_entry_t       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty_o = (count == '0);
  assign full_o  = (count == CNT_W'(DEPTH));
  assign count_o = count;
  assign head_o  = mem[rd_ptr];
  assign do_pop  = pop_i && !empty_o;

  // Pointers and occupancy; simultaneous push and pop leave count unchanged.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_i) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop) rd_ptr <= ptr_inc(rd_ptr);
      case ({push_i, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: ;
      endcase
    end
  end

  // Entry storage.
  always_ff @(posedge clk_i) begin
    if (push_i) mem[wr_ptr] <= entry_i;
  end

  // The arbiter's credit check must make an overrun impossible.
  always_ff @(posedge clk_i) begin
    if (rst_ni) assert (!(push_i && full_o)) else $error("mul_rsp_fifo: push while full");
  end

endmodule

// File: rtl/mul_share_mult.sv
// mul_share_mult: two-stage multiplier. Stage 1 sign/zero-extends the
// operands to 33 bits and registers them; stage 2 forms the 66-bit product
// and selects the low or high word. Reset is synchronous, active high.
module mul_share_mult
  import mul_share_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  OPERATOR_t   op_i,
  input  logic [31:0] op1_i,
  input  logic [31:0] op2_i,
  output logic [31:0] result_o
);

  OPERATOR_t          op_q;
  logic signed [32:0] a_ext, b_ext;
  logic signed [32:0] a_q, b_q;
  logic signed [65:0] prod;
  logic               unused_prod_top;

  // Extend each operand according to the signedness the operator implies.
  always_comb begin
    a_ext = {1'b0, op1_i};
    b_ext = {1'b0, op2_i};
    case (op_i)
      _MUL, _MULH: begin
        a_ext = {op1_i[31], op1_i};
        b_ext = {op2_i[31], op2_i};
      end
      _MULHSU: a_ext = {op1_i[31], op1_i};
      default: ;
    endcase
  end

  // Stage-1 operand register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      op_q <= _ADD;
      a_q  <= '0;
      b_q  <= '0;
    end else begin
      op_q <= op_i;
      a_q  <= a_ext;
      b_q  <= b_ext;
    end
  end

  assign prod            = 66'(a_q) * 66'(b_q);
  assign unused_prod_top = ^prod[65:64];

  // Stage-2 result select.
  always_comb begin
    case (op_q)
      _ADD:    result_o = a_q[31:0] + b_q[31:0];
      _MUL:    result_o = prod[31:0];
      default: result_o = prod[63:32];
    endcase
  end

endmodule

// File: rtl/mul_share_arbiter.sv
// mul_share_arbiter: round-robin sharing of one two-stage multiplier among
// NUM_REQ requesters, with a credit-protected in-order response FIFO.
// Optional macro MUL_SHARE_ARB_PERF_EN enables grant/stall counters; without
// it the perf ports are tied to zero.
module mul_share_arbiter
  import mul_share_pkg::*;
#(
  parameter int NUM_REQ   = 2,
  parameter int TAG_W     = 4,
  parameter int RSP_DEPTH = 4
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic [NUM_REQ-1:0]             req_valid_i,
  output logic [NUM_REQ-1:0]             req_ready_o,
  input  OPERATOR_t [NUM_REQ-1:0]        req_op_i,
  input  logic [NUM_REQ-1:0][31:0]       req_op1_i,
  input  logic [NUM_REQ-1:0][31:0]       req_op2_i,
  input  logic [NUM_REQ-1:0][TAG_W-1:0]  req_tag_i,
  output logic [NUM_REQ-1:0]             rsp_valid_o,
  input  logic [NUM_REQ-1:0]             rsp_ready_i,
  output logic [31:0]                    rsp_data_o,
  output logic [TAG_W-1:0]               rsp_tag_o,
  output logic [NUM_REQ-1:0][31:0]       perf_grant_o,
  output logic [31:0]                    perf_stall_o
);

  localparam int REQ_ID_W = req_id_w(NUM_REQ);
  localparam int CNT_W    = $clog2(RSP_DEPTH + 1);

  if (NUM_REQ < 2 || REQ_ID_W > ID_W_MAX || TAG_W > TAG_W_MAX || RSP_DEPTH < 2) begin : g_param_check
    $error("mul_share_arbiter: unsupported parameter set");
  end

  logic [REQ_ID_W-1:0] rr_ptr, winner;
  logic                any_valid, can_issue, issue;
  logic                sh_valid;
  logic [REQ_ID_W-1:0] sh_id;
  logic [TAG_W-1:0]    sh_tag;
  OPERATOR_t           mul_op;
  logic [31:0]         mul_op1, mul_op2, mul_result;
  rsp_entry_t          push_entry, head;
  logic [CNT_W-1:0]    fifo_count;
  logic                fifo_empty, pop;
  logic                unused_fifo_full, unused_head_bits;

  // Credit: entries held plus the op still in the multiplier must leave room.
  // A pop in the same cycle is not counted, keeping this off the rsp_ready path.
  assign can_issue = (int'(fifo_count) + int'(sh_valid)) < RSP_DEPTH;
  assign issue     = rst_ni && can_issue && any_valid;

  // Round-robin pick: first valid requester at or after rr_ptr.
  always_comb begin
    winner    = '0;
    any_valid = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_valid_i[rr_index(int'(rr_ptr), k, NUM_REQ)]) begin
        winner    = REQ_ID_W'(rr_index(int'(rr_ptr), k, NUM_REQ));
        any_valid = 1'b1;
      end
    end
  end

  // Grant vector and multiplier operand mux; idle cycles feed an add of zeros.
  always_comb begin
    req_ready_o = '0;
    mul_op      = _ADD;
    mul_op1     = '0;
    mul_op2     = '0;
    if (issue) begin
      req_ready_o[winner] = 1'b1;
      mul_op              = req_op_i[winner];
      mul_op1             = req_op1_i[winner];
      mul_op2             = req_op2_i[winner];
    end
  end

  // RR pointer and the shadow of the op now in multiplier stage 2.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rr_ptr   <= '0;
      sh_valid <= 1'b0;
      sh_id    <= '0;
      sh_tag   <= '0;
    end else begin
      sh_valid <= issue;
      if (issue) begin
        rr_ptr <= (int'(winner) == NUM_REQ - 1) ? '0 : winner + REQ_ID_W'(1);
        sh_id  <= winner;
        sh_tag <= req_tag_i[winner];
      end
    end
  end

  mul_share_mult u_mult (
    .clk_i    (clk_i),
    .rst_i    (~rst_ni),
    .op_i     (mul_op),
    .op1_i    (mul_op1),
    .op2_i    (mul_op2),
    .result_o (mul_result)
  );

  // Entry pushed when the shadowed op leaves stage 2.
  always_comb begin
    push_entry      = '0;
    push_entry.id   = ID_W_MAX'(sh_id);
    push_entry.tag  = TAG_W_MAX'(sh_tag);
    push_entry.data = mul_result;
  end

  mul_rsp_fifo #(
    .DEPTH (RSP_DEPTH),
    .CNT_W (CNT_W)
  ) u_rsp_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (sh_valid),
    .entry_i (push_entry),
    .pop_i   (pop),
    .head_o  (head),
    .count_o (fifo_count),
    .empty_o (fifo_empty),
    .full_o  (unused_fifo_full)
  );

  // Head is offered only to its owner; other requesters wait behind it.
  always_comb begin
    rsp_valid_o = '0;
    rsp_data_o  = '0;
    rsp_tag_o   = '0;
    if (!fifo_empty) begin
      rsp_valid_o[head.id[REQ_ID_W-1:0]] = 1'b1;
      rsp_data_o                         = head.data;
      rsp_tag_o                          = head.tag[TAG_W-1:0];
    end
  end

  assign pop              = |(rsp_valid_o & rsp_ready_i);
  assign unused_head_bits = ^{head.id, head.tag};

`ifdef MUL_SHARE_ARB_PERF_EN
  logic [NUM_REQ-1:0][31:0] grant_cnt;
  logic [31:0]              stall_cnt;

  // Grant and stall event counters, wrapping at 32 bits.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      grant_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      if (issue) grant_cnt[winner] <= grant_cnt[winner] + 32'd1;
      if (any_valid && !issue) stall_cnt <= stall_cnt + 32'd1;
    end
  end

  assign perf_grant_o = grant_cnt;
  assign perf_stall_o = stall_cnt;
`else
  assign perf_grant_o = '0;
  assign perf_stall_o = '0;
`endif

endmodule

// File: tb/tb_mul_share_arbiter.sv
// tb_mul_share_arbiter: directed checks of grant order, latency, arithmetic,
// credit back-pressure, head-of-line ordering and reset behaviour.
module tb_mul_share_arbiter;
  import mul_share_pkg::*;

  localparam int NR = 2;
  localparam int TW = 4;

  logic                     clk_i = 1'b0;
  logic                     rst_ni;
  logic [NR-1:0]            req_valid_i, req_ready_o, rsp_valid_o, rsp_ready_i;
  OPERATOR_t [NR-1:0]       req_op_i;
  logic [NR-1:0][31:0]      req_op1_i, req_op2_i, perf_grant_o;
  logic [NR-1:0][TW-1:0]    req_tag_i;
  logic [31:0]              rsp_data_o, perf_stall_o;
  logic [TW-1:0]            rsp_tag_o;

  int n_chk = 0;
  int n_bad = 0;
  logic [31:0] drain_exp [4] = '{32'd20, 32'd30, 32'd40, 32'd90};

  always #5 clk_i = ~clk_i;

  mul_share_arbiter #(.NUM_REQ(NR), .TAG_W(TW), .RSP_DEPTH(4)) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_op_i     (req_op_i),
    .req_op1_i    (req_op1_i),
    .req_op2_i    (req_op2_i),
    .req_tag_i    (req_tag_i),
    .rsp_valid_o  (rsp_valid_o),
    .rsp_ready_i  (rsp_ready_i),
    .rsp_data_o   (rsp_data_o),
    .rsp_tag_o    (rsp_tag_o),
    .perf_grant_o (perf_grant_o),
    .perf_stall_o (perf_stall_o)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_req(input int r, input OPERATOR_t op, input logic [31:0] a,
                         input logic [31:0] b, input logic [TW-1:0] tag);
    req_op_i[r]  = op;
    req_op1_i[r] = a;
    req_op2_i[r] = b;
    req_tag_i[r] = tag;
  endtask

  // Single op with rsp_ready high: grant now, response exactly two cycles later.
  task automatic run_op(input string name, input int r, input OPERATOR_t op, input logic [31:0] a,
                        input logic [31:0] b, input logic [TW-1:0] tag, input logic [31:0] exp);
    req_valid_i    = '0;
    req_valid_i[r] = 1'b1;
    set_req(r, op, a, b, tag);
    #1 chk({name, "_grant"}, req_ready_o, 64'(1 << r));
    tick();
    req_valid_i = '0;
    #1 chk({name, "_lat1"}, rsp_valid_o, 0);
    tick();
    chk({name, "_valid"}, rsp_valid_o, 64'(1 << r));
    chk({name, "_data"}, rsp_data_o, exp);
    chk({name, "_tag"}, rsp_tag_o, tag);
    tick();
    chk({name, "_popped"}, rsp_valid_o, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench exceeded its time limit");
    $fatal(1);
  end

  initial begin
    rst_ni      = 1'b0;
    rsp_ready_i = '0;
    for (int r = 0; r < NR; r++) set_req(r, _ADD, '0, '0, '0);
    req_valid_i = 2'b11;
    tick();
    tick();
    #1;
    chk("rst_ready", req_ready_o, 0);
    chk("rst_rsp_valid", rsp_valid_o, 0);
    chk("rst_rsp_data", rsp_data_o, 0);
    chk("rst_rsp_tag", rsp_tag_o, 0);
    chk("rst_perf_grant", perf_grant_o, 0);
    chk("rst_perf_stall", perf_stall_o, 0);
    req_valid_i = '0;
    rst_ni      = 1'b1;
    tick();

    // Both requesters always valid: alternating grants, one result per cycle.
    rsp_ready_i = 2'b11;
    for (int c = 0; c < 10; c++) begin
      if (c < 8) begin
        req_valid_i = 2'b11;
        set_req(0, _MUL, 32'(c + 1), 32'd3, TW'(c));
        set_req(1, _MUL, 32'(c + 1), 32'd5, TW'(c));
      end else begin
        req_valid_i = '0;
      end
      #1;
      if (c < 8) chk("rr_grant", req_ready_o, (c % 2 == 0) ? 64'd1 : 64'd2);
      if (c >= 2) begin
        chk("rr_rsp_valid", rsp_valid_o, ((c - 2) % 2 == 0) ? 64'd1 : 64'd2);
        chk("rr_rsp_data", rsp_data_o, 64'((c - 1) * (((c - 2) % 2 == 0) ? 3 : 5)));
        chk("rr_rsp_tag", rsp_tag_o, 64'((c - 2) % 16));
      end
      tick();
    end
    chk("rr_drained", rsp_valid_o, 0);
`ifdef MUL_SHARE_ARB_PERF_EN
    chk("perf_grant0", perf_grant_o[0], 4);
    chk("perf_grant1", perf_grant_o[1], 4);
    chk("perf_stall", perf_stall_o, 0);
`else
    chk("perf_grant_off", perf_grant_o, 0);
    chk("perf_stall_off", perf_stall_o, 0);
`endif

    // Single-op latency and arithmetic.
    run_op("mul_basic", 0, _MUL, 32'd7, 32'd6, 4'd3, 32'd42);
    run_op("mulh_m1", 0, _MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd1, 32'h0);
    run_op("mulhu_m1", 1, _MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd2, 32'hFFFF_FFFE);
    run_op("mulhsu_m1", 0, _MULHSU, 32'hFFFF_FFFF, 32'd2, 4'd4, 32'hFFFF_FFFF);
    run_op("mul_neg", 1, _MUL, 32'hFFFF_FFFD, 32'd5, 4'd5, 32'hFFFF_FFF1);
    run_op("mulh_min", 0, _MULH, 32'h8000_0000, 32'h8000_0000, 4'd6, 32'h4000_0000);
    run_op("mulhsu_min", 1, _MULHSU, 32'h8000_0000, 32'hFFFF_FFFF, 4'd7, 32'h8000_0000);
    run_op("mulhu_min", 0, _MULHU, 32'h8000_0000, 32'hFFFF_FFFF, 4'd8, 32'h7FFF_FFFF);

    // Credit back-pressure: four grants fill the FIFO, then one pop frees one slot.
    rsp_ready_i = '0;
    for (int c = 0; c < 7; c++) begin
      req_valid_i = 2'b01;
      set_req(0, _MUL, 32'(c + 1), 32'd10, TW'(c));
      #1 chk("cr_grant", req_ready_o, (c < 4) ? 64'd1 : 64'd0);
      tick();
    end
    set_req(0, _MUL, 32'd8, 32'd10, 4'd7);
    #1;
    chk("cr_head_valid", rsp_valid_o, 1);
    chk("cr_head_data", rsp_data_o, 10);
    chk("cr_full_grant", req_ready_o, 0);
    rsp_ready_i = 2'b01;
    #1 chk("cr_pop_no_credit", req_ready_o, 0);
    tick();
    rsp_ready_i = '0;
    set_req(0, _MUL, 32'd9, 32'd10, 4'd8);
    #1 chk("cr_regrant", req_ready_o, 1);
    tick();
    #1 chk("cr_regrant_once", req_ready_o, 0);
    req_valid_i = '0;
    rsp_ready_i = 2'b01;
    for (int k = 0; k < 4; k++) begin
      #1 chk("cr_drain_data", rsp_data_o, drain_exp[k]);
      tick();
    end
    #1 chk("cr_drained", rsp_valid_o, 0);

    // Head-of-line: req1 result at head blocks req0's result behind it.
    rsp_ready_i = 2'b01;
    req_valid_i = 2'b10;
    set_req(1, _MUL, 32'd2, 32'd3, 4'd1);
    #1 chk("hol_grant1", req_ready_o, 2);
    tick();
    req_valid_i = 2'b01;
    set_req(0, _MUL, 32'd4, 32'd5, 4'd2);
    #1 chk("hol_grant0", req_ready_o, 1);
    tick();
    req_valid_i = '0;
    for (int k = 0; k < 3; k++) begin
      chk("hol_blocked_valid", rsp_valid_o, 2);
      chk("hol_blocked_data", rsp_data_o, 6);
      tick();
    end
    rsp_ready_i = 2'b10;
    tick();
    chk("hol_next_valid", rsp_valid_o, 1);
    chk("hol_next_data", rsp_data_o, 20);
    chk("hol_next_tag", rsp_tag_o, 2);
    tick();
    chk("hol_wrong_ready", rsp_valid_o, 1);
    rsp_ready_i = 2'b11;
    tick();
    chk("hol_drained", rsp_valid_o, 0);

    // Reset with one op in flight and two entries queued.
    rsp_ready_i = '0;
    for (int c = 0; c < 3; c++) begin
      req_valid_i = 2'b01;
      set_req(0, _MUL, 32'(c + 1), 32'd1, TW'(c));
      #1 chk("mr_grant", req_ready_o, 1);
      tick();
    end
    req_valid_i = '0;
    #1 chk("mr_head_before", rsp_valid_o, 1);
    rst_ni = 1'b0;
    tick();
    rst_ni = 1'b1;
    #1;
    chk("mr_ready", req_ready_o, 0);
    chk("mr_rsp_valid", rsp_valid_o, 0);
    chk("mr_rsp_data", rsp_data_o, 0);
    chk("mr_rsp_tag", rsp_tag_o, 0);
    chk("mr_perf_grant", perf_grant_o, 0);
    chk("mr_perf_stall", perf_stall_o, 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("mr_no_stale", rsp_valid_o, 0);
    end
    req_valid_i = 2'b11;
    #1 chk("mr_rr_ptr", req_ready_o, 1);
    req_valid_i = '0;
    rsp_ready_i = 2'b11;
    tick();
    run_op("mr_after", 1, _MUL, 32'd11, 32'd3, 4'd9, 32'd33);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
